// File: rtl/ysyx_041461_commit_if.sv
// Commit-stage handshake bundle: commit request from the previous stage
// (in_*) and the redirect request to IF (redir_*); master drives requests.
interface ysyx_041461_commit_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic            in_wen;
  logic [AW-1:0]   in_rd;
  logic [XLEN-1:0] in_data;
  logic [XLEN-1:0] in_pc;
  logic            in_trap;
  logic [XLEN-1:0] in_cause;
  logic            redir_valid;
  logic            redir_ready;
  logic [XLEN-1:0] redir_pc;

  modport master (
    output in_valid, in_wen, in_rd, in_data,
    output in_pc, in_trap, in_cause,
    output redir_ready,
    input  in_ready, redir_valid, redir_pc
  );

  modport slave (
    input  in_valid, in_wen, in_rd, in_data,
    input  in_pc, in_trap, in_cause,
    input  redir_ready,
    output in_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/ysyx_041461_commit.sv
// Commit stage: register file writeback, trap entry (mepc/mcause, redirect
// to mtvec) and mcycle/minstret counters.
// Ports: clk, rst (sync, active-high); cmt = commit/redirect handshake
// bundle (slave side); mtvec in; rd_addr/rd_data = NRD flattened read
// ports; mepc_o, mcause_o, mcycle_o, minstret_o = CSR values.
// Option: define YSYX_041461_COMMIT_BYPASS_EN to forward an accepted
// write to read ports in the same cycle.
module ysyx_041461_commit #(
  parameter  int XLEN = 64,
  parameter  int NREG = 32,
  parameter  int NRD  = 4,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_041461_commit_if.slave cmt,
  input  logic [XLEN-1:0]     mtvec,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [XLEN-1:0]     mepc_o,
  output logic [XLEN-1:0]     mcause_o,
  output logic [XLEN-1:0]     mcycle_o,
  output logic [XLEN-1:0]     minstret_o
);

  typedef enum logic {
    IDLE,
    REDIR
  } state_t;

  state_t          state;
  logic            ready_q;
  logic            redir_q;
  logic [XLEN-1:0] rpc_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mcycle_q;
  logic [XLEN-1:0] minstret_q;
  logic [XLEN-1:0] regs [NREG];

  logic acc;
  logic trap_acc;
  logic ret_acc;
  logic wr_en;

  assign acc      = cmt.in_valid & ready_q;
  assign trap_acc = acc & cmt.in_trap;
  assign ret_acc  = acc & ~cmt.in_trap;
  assign wr_en    = ret_acc & cmt.in_wen
                  & (cmt.in_rd != '0);

  assign cmt.in_ready    = ready_q;
  assign cmt.redir_valid = redir_q;
  assign cmt.redir_pc    = rpc_q;

  assign mepc_o     = mepc_q;
  assign mcause_o   = mcause_q;
  assign mcycle_o   = mcycle_q;
  assign minstret_o = minstret_q;

  // ready/redirect flags are registered copies of the state so the
  // handshake outputs never glitch on the request inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      redir_q    <= 1'b0;
      rpc_q      <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q <= mcycle_q + 1'b1;
      if (ret_acc)
        minstret_q <= minstret_q + 1'b1;
      if (trap_acc) begin
        mepc_q   <= cmt.in_pc;
        mcause_q <= cmt.in_cause;
      end
      unique case (state)
        IDLE: begin
          if (trap_acc) begin
            state   <= REDIR;
            ready_q <= 1'b0;
            redir_q <= 1'b1;
            rpc_q   <= mtvec;
          end
        end
        REDIR: begin
          if (cmt.redir_ready) begin
            state   <= IDLE;
            ready_q <= 1'b1;
            redir_q <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[cmt.in_rd] <= cmt.in_data;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] v;
      a = rd_addr[k*AW +: AW];
      v = (a == '0) ? '0 : regs[a];
`ifdef YSYX_041461_COMMIT_BYPASS_EN
      if (wr_en && (cmt.in_rd == a))
        v = cmt.in_data;
`endif
      rd_data[k*XLEN +: XLEN] = v;
    end
  end

endmodule

// File: tb/tb_ysyx_041461_commit.sv
// Bench for ysyx_041461_commit: directed vector table, counter wrap
// sequence, then random traffic against a behavioural model.
module tb_ysyx_041461_commit;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int AW   = 5;
`ifdef YSYX_041461_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [63:0] MT = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic [XLEN-1:0] mtvec;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [XLEN-1:0] mepc, mcause, mcycle, minstret;

  ysyx_041461_commit_if #(.XLEN(XLEN), .AW(AW)) cif ();

  ysyx_041461_commit #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .cmt(cif), .mtvec(mtvec),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .mepc_o(mepc), .mcause_o(mcause),
    .mcycle_o(mcycle), .minstret_o(minstret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  logic [63:0] m_x [NREG];
  logic [63:0] m_mepc, m_mcause, m_cyc, m_inst, m_rpc;
  bit m_redir;

  typedef struct {
    bit chk, rst, vld, wen, trap, rdy;
    logic [4:0] rd, a0, a1;
    logic [63:0] data, pc, cause;
    bit e_rdy, e_rv;
    logic [63:0] e_rpc, e_d0, e_d1, e_mepc, e_mcause, e_inst;
  } vec_t;

  vec_t tv [17];

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s got %h expected %h", nm, a, e);
    end
  endtask

  task automatic model_check();
    chk("m_ready", {63'd0, cif.in_ready}, {63'd0, !m_redir});
    chk("m_redir", {63'd0, cif.redir_valid}, {63'd0, m_redir});
    if (m_redir) chk("m_rpc", cif.redir_pc, m_rpc);
    chk("m_mepc", mepc, m_mepc);
    chk("m_mcause", mcause, m_mcause);
    chk("m_mcycle", mcycle, m_cyc);
    chk("m_minstret", minstret, m_inst);
    for (int k = 0; k < NRD; k++) begin
      logic [4:0] a;
      logic [63:0] e;
      a = rd_addr[k*AW +: AW];
      e = m_x[a];
      if (BYP && cif.in_valid && !m_redir && !cif.in_trap &&
          cif.in_wen && cif.in_rd != 0 && cif.in_rd == a)
        e = cif.in_data;
      chk($sformatf("m_rd%0d", k), rd_data[k*XLEN +: XLEN], e);
    end
  endtask

  task automatic model_update();
    bit was, acc;
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_x[i] = 0;
      m_mepc = 0; m_mcause = 0; m_cyc = 0; m_inst = 0;
      m_rpc = 0; m_redir = 0;
    end else begin
      was = m_redir;
      acc = cif.in_valid && !was;
      m_cyc = m_cyc + 1;
      if (was && cif.redir_ready) m_redir = 0;
      if (acc && cif.in_trap) begin
        m_mepc = cif.in_pc;
        m_mcause = cif.in_cause;
        m_rpc = mtvec;
        m_redir = 1;
      end else if (acc) begin
        m_inst = m_inst + 1;
        if (cif.in_wen && cif.in_rd != 0) m_x[cif.in_rd] = cif.in_data;
      end
    end
  endtask

  task automatic tick(input bit mchk);
    #1;
    if (mchk) model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_in();
    rst = 0;
    cif.in_valid = 0; cif.in_wen = 0; cif.in_trap = 0;
    cif.in_rd = 0; cif.in_data = 0; cif.in_pc = 0; cif.in_cause = 0;
    cif.redir_ready = 0;
    rd_addr = '0;
  endtask

  initial begin
    mtvec = MT;
    idle_in();
    m_redir = 0;
    m_rpc = 0;
    m_mepc = 0; m_mcause = 0; m_cyc = 0; m_inst = 0;
    for (int i = 0; i < NREG; i++) m_x[i] = 0;

    tv[0]  = '{0,1,0,0,0,0, 0,0,0, 0,0,0,
               1,0,0,0,0,0,0,0};
    tv[1]  = '{1,1,0,0,0,0, 0,0,0, 0,0,0,
               1,0,0,0,0,0,0,0};
    tv[2]  = '{1,0,1,1,0,0, 5,5,5, 'h1234,0,0,
               1,0,0,BYP ? 'h1234 : 0,BYP ? 'h1234 : 0,0,0,0};
    tv[3]  = '{1,0,0,0,0,0, 0,5,0, 0,0,0,
               1,0,0,'h1234,0,0,0,1};
    tv[4]  = '{1,0,1,1,0,0, 0,0,0, 'hFFFF,0,0,
               1,0,0,0,0,0,0,1};
    tv[5]  = '{1,0,0,0,0,0, 0,0,0, 0,0,0,
               1,0,0,0,0,0,0,2};
    tv[6]  = '{1,0,1,1,1,0, 5,5,0, 'hDEAD,'h100,11,
               1,0,0,'h1234,0,0,0,2};
    tv[7]  = '{1,0,1,1,0,0, 5,5,0, 'h5555,0,0,
               0,1,MT,'h1234,0,'h100,11,2};
    tv[8]  = tv[7];
    tv[9]  = tv[7];
    tv[10] = '{1,0,0,0,0,1, 0,5,0, 0,0,0,
               0,1,MT,'h1234,0,'h100,11,2};
    tv[11] = '{1,0,0,0,0,0, 0,5,0, 0,0,0,
               1,0,0,'h1234,0,'h100,11,2};
    tv[12] = '{1,0,1,1,0,0, 7,5,7, 'hAA,0,0,
               1,0,0,'h1234,BYP ? 'hAA : 0,'h100,11,2};
    tv[13] = '{1,0,0,0,0,0, 0,5,7, 0,0,0,
               1,0,0,'h1234,'hAA,'h100,11,3};
    tv[14] = '{1,0,1,0,1,0, 0,5,7, 0,'h200,2,
               1,0,0,'h1234,'hAA,'h100,11,3};
    tv[15] = '{1,1,0,0,0,0, 0,5,7, 0,0,0,
               0,1,MT,'h1234,'hAA,'h200,2,3};
    tv[16] = '{1,0,0,0,0,0, 0,5,7, 0,0,0,
               1,0,0,0,0,0,0,0};

    for (int i = 0; i < 17; i++) begin
      rst = tv[i].rst;
      cif.in_valid = tv[i].vld;
      cif.in_wen = tv[i].wen;
      cif.in_trap = tv[i].trap;
      cif.redir_ready = tv[i].rdy;
      cif.in_rd = tv[i].rd;
      cif.in_data = tv[i].data;
      cif.in_pc = tv[i].pc;
      cif.in_cause = tv[i].cause;
      rd_addr = '0;
      rd_addr[0 +: AW] = tv[i].a0;
      rd_addr[AW +: AW] = tv[i].a1;
      #1;
      if (tv[i].chk) begin
        chk($sformatf("tv%0d_ready", i),
            {63'd0, cif.in_ready}, {63'd0, tv[i].e_rdy});
        chk($sformatf("tv%0d_redir", i),
            {63'd0, cif.redir_valid}, {63'd0, tv[i].e_rv});
        if (tv[i].e_rv)
          chk($sformatf("tv%0d_rpc", i), cif.redir_pc, tv[i].e_rpc);
        chk($sformatf("tv%0d_rd0", i), rd_data[0 +: XLEN], tv[i].e_d0);
        chk($sformatf("tv%0d_rd1", i), rd_data[XLEN +: XLEN], tv[i].e_d1);
        chk($sformatf("tv%0d_mepc", i), mepc, tv[i].e_mepc);
        chk($sformatf("tv%0d_mcause", i), mcause, tv[i].e_mcause);
        chk($sformatf("tv%0d_minstret", i), minstret, tv[i].e_inst);
      end
      tick(i > 0);
    end

    idle_in();
    force dut.mcycle_q = '1;
    #1;
    release dut.mcycle_q;
    m_cyc = '1;
    tick(1);
    #1;
    chk("wrap_mcycle", mcycle, 64'd0);
    tick(1);

    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(63) == 0);
      cif.in_valid = $urandom_range(1);
      cif.in_trap = ($urandom_range(7) == 0);
      cif.in_wen = ($urandom_range(3) != 0);
      cif.in_rd = 5'($urandom_range(31));
      cif.in_data = {$urandom, $urandom};
      cif.in_pc = {$urandom, $urandom};
      cif.in_cause = {$urandom, $urandom};
      cif.redir_ready = $urandom_range(1);
      mtvec = {$urandom, $urandom};
      for (int k = 0; k < NRD; k++) begin
        if ($urandom_range(1) == 1)
          rd_addr[k*AW +: AW] = cif.in_rd;
        else
          rd_addr[k*AW +: AW] = 5'($urandom_range(31));
      end
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end
endmodule

// File: doc/ysyx_041461_commit.md
YSYX_041461_COMMIT -- requirements
Module: ysyx_041461_commit

Interface
REQ-001 Parameter XLEN, default 64: register and datapath width.
REQ-002 Parameter NREG, default 32: number of architectural registers; must be a power of two and at least 2; AW = log2(NREG).
REQ-003 Parameter NRD, default 4: number of independent combinational read ports.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 in_valid  input  1  commit request from the previous stage.
REQ-007 in_ready  output  1  block accepts a commit this cycle.
REQ-008 in_wen  input  1  request writes the register file.
REQ-009 in_rd  input  AW  destination register index.
REQ-010 in_data  input  XLEN  write data.
REQ-011 in_pc  input  XLEN  pc of the committing instruction.
REQ-012 in_trap  input  1  instruction traps; no register write.
REQ-013 in_cause  input  XLEN  cause value for a trap.
REQ-014 mtvec  input  XLEN  trap vector, supplied by the CSR file.
REQ-015 rd_addr  input  NRD*AW  flattened read indices; port k uses bits [k*AW +: AW].
REQ-016 rd_data  output  NRD*XLEN  flattened read data; port k uses bits [k*XLEN +: XLEN].
REQ-017 redir_valid  output  1  redirect request to IF.
REQ-018 redir_ready  input  1  IF accepts the redirect.
REQ-019 redir_pc  output  XLEN  redirect target.
REQ-020 mepc_o, mcause_o, mcycle_o, minstret_o  output  XLEN each  current CSR values.

Function
REQ-021 Accept occurs when in_valid=1 and in_ready=1 in the same cycle; in_ready shall be 1 exactly when the FSM is in IDLE.
REQ-022 FSM states:
- IDLE -> REDIR on an accepted request with in_trap=1.
- REDIR -> IDLE in the cycle redir_valid=1 and redir_ready=1.
- All other cases hold the current state.
REQ-023 An accepted request with in_trap=0 and in_wen=1 and in_rd!=0 shall write x[in_rd] at that edge.
REQ-024 Register 0 shall always read 0; writes to register 0 are discarded.
REQ-025 An accepted request with in_trap=1 shall:
- not write the register file;
- load mepc<=in_pc and mcause<=in_cause;
- latch mtvec into redir_pc at the same edge.
REQ-026 In REDIR, redir_valid=1 and redir_pc is held stable until the handshake completes.
REQ-027 redir_valid shall be 0 in IDLE.
REQ-028 mcycle shall increment by 1 every non-reset cycle and wrap modulo 2^XLEN.
REQ-029 minstret shall increment by 1 only on an accepted request with in_trap=0, and wrap modulo 2^XLEN.
REQ-030 Read port k shall drive x[rd_addr_k] combinationally; all ports are independent and may alias the same register.
REQ-031 A committed write shall be visible on the read ports in the cycle after acceptance; same-cycle visibility is governed by REQ-036.
REQ-032 in_valid while in REDIR shall not be accepted and shall have no side effects.

Reset
REQ-033 While rst=1 at a rising edge: every x[i], mepc, mcause, mcycle, minstret and redir_pc shall become 0, and the FSM shall enter IDLE.
REQ-034 After reset: in_ready=1, redir_valid=0, and all rd_data=0.
REQ-035 Reset asserted in REDIR shall abandon the redirect; redir_valid=0 from the next cycle.

Configuration
REQ-036 Macro YSYX_041461_COMMIT_BYPASS_EN:
- Defined: when a non-trap write to rd!=0 is being accepted this cycle, any read port addressing that rd shall return in_data combinationally in the same cycle.
- Undefined: read ports return only stored values, and the write is visible the next cycle.

Verification
REQ-037 Reset then write: rst for 2 cycles; commit rd=5, data=0x1234, wen=1 -> port 0 reads 0x1234 the next cycle; minstret=1.
REQ-038 Write to register 0: commit rd=0, data=0xFFFF -> all ports addressing 0 read 0; minstret increments.
REQ-039 Trap with stalled IF: mtvec=0x8000_0000, trap pc=0x100, cause=11, redir_ready=0 for 3 cycles ->
- redir_valid=1 and in_ready=0 for those 3 cycles;
- mepc=0x100, mcause=11, no register write, minstret unchanged;
- IDLE the cycle after redir_ready=1.
REQ-040 Bypass: with BYPASS_EN, accept rd=7, data=0xAA while rd_addr_1=7 -> rd_data_1=0xAA in the same cycle; without BYPASS_EN -> old value that cycle, 0xAA the next.
REQ-041 Counter wrap: mcycle preloaded to all-ones (via a bench force) -> 0 the next cycle.
REQ-042 Reset in REDIR: rst in REDIR -> redir_valid=0, in_ready=1, mepc=0 the next cycle.
